// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl: counts matches of a 4-bit pattern in a serial bit window; define SEQ_OVERLAP_EN to count overlapping matches
module pattern_scan_ctrl #(
    parameter int WIN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       pattern,
    input  logic [WIN_W-1:0] win_len,
    input  logic             in,
    input  logic             in_valid,
    output logic             busy,
    output logic             done,
    output logic             hit,
    output logic [WIN_W-1:0] match_cnt,
    output logic [WIN_W-1:0] first_pos
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    state_t           state;
    logic [3:0]       pat;
    logic [2:0]       hist;
    logic [WIN_W-1:0] len;
    logic [WIN_W-1:0] idx;
    logic [2:0]       elig;
    logic [2:0]       elig_inc;
    logic [2:0]       elig_nxt;
    logic             match;

    // match detection and eligible-bit bookkeeping for the bit consumed this cycle
    always_comb begin
        match    = state == SCAN && in_valid && {hist, in} == pat && elig >= 3'd3;
        elig_inc = elig == 3'd4 ? elig : elig + 3'd1;
`ifdef SEQ_OVERLAP_EN
        elig_nxt = elig_inc;
`else
        elig_nxt = match ? 3'd0 : elig_inc;
`endif
    end

    // scan FSM with registered Moore outputs and match counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            hit       <= 1'b0;
            match_cnt <= '0;
            first_pos <= '1;
            hist      <= '0;
            elig      <= '0;
            idx       <= '0;
            pat       <= '0;
            len       <= '0;
        end else begin
            hit <= 1'b0;
            case (state)
                SCAN: begin
                    if (in_valid) begin
                        hist <= {hist[1:0], in};
                        idx  <= idx + 1'b1;
                        elig <= elig_nxt;
                        if (match) begin
                            hit       <= 1'b1;
                            match_cnt <= &match_cnt ? match_cnt : match_cnt + 1'b1;
                            if (match_cnt == '0)
                                first_pos <= idx;
                        end
                        if (idx == len - 1'b1) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                IDLE, DONE: begin
                    if (start) begin
                        pat       <= pattern;
                        len       <= win_len;
                        match_cnt <= '0;
                        first_pos <= '1;
                        hist      <= '0;
                        idx       <= '0;
                        elig      <= '0;
                        state     <= win_len == '0 ? DONE : SCAN;
                        busy      <= win_len != '0;
                        done      <= win_len == '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// tb_pattern_scan_ctrl: directed stimulus against a bit-queue reference model plus literal result checks
module tb_pattern_scan_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] pattern = 4'd0;
    logic [7:0] win_len = 8'd0;
    logic       din = 1'b0;
    logic       in_valid = 1'b0;
    logic       busy, done, hit;
    logic [7:0] match_cnt, first_pos;
    logic       busy3, done3, hit3;
    logic [2:0] match_cnt3, first_pos3;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    pattern_scan_ctrl #(.WIN_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .pattern(pattern), .win_len(win_len),
        .in(din), .in_valid(in_valid), .busy(busy), .done(done), .hit(hit),
        .match_cnt(match_cnt), .first_pos(first_pos)
    );

    pattern_scan_ctrl #(.WIN_W(3)) dut3 (
        .clk(clk), .rst(rst), .start(start), .pattern(pattern), .win_len(win_len[2:0]),
        .in(din), .in_valid(in_valid), .busy(busy3), .done(done3), .hit(hit3),
        .match_cnt(match_cnt3), .first_pos(first_pos3)
    );

    always #5 clk = ~clk;

`ifdef SEQ_OVERLAP_EN
    localparam bit OVERLAP = 1'b1;
`else
    localparam bit OVERLAP = 1'b0;
`endif

    // reference model: keeps every consumed bit and rescans the tail for matches
    int         m_mode = 0;
    bit         m_hit = 1'b0;
    logic [7:0] m_cnt = 8'd0;
    logic [7:0] m_first = 8'hFF;
    logic [3:0] m_pat = 4'd0;
    int         m_len = 0;
    int         m_last = -1;
    bit         q[$];

    always @(posedge clk) begin
        if (rst) begin
            m_mode = 0; m_hit = 1'b0; m_cnt = 8'd0; m_first = 8'hFF; q.delete();
        end else begin
            m_hit = 1'b0;
            if (m_mode != 1 && start) begin
                m_pat = pattern; m_len = int'(win_len); m_cnt = 8'd0; m_first = 8'hFF;
                q.delete(); m_last = -1;
                m_mode = (m_len == 0) ? 2 : 1;
            end else if (m_mode == 1 && in_valid) begin
                int k;
                q.push_back(din);
                k = q.size() - 1;
                if (k >= 3 && {q[k-3], q[k-2], q[k-1], q[k]} == m_pat && (OVERLAP || k - m_last >= 4)) begin
                    m_hit = 1'b1;
                    if (m_cnt == 8'd0) m_first = 8'(k);
                    if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
                    m_last = k;
                end
                if (q.size() == m_len) m_mode = 2;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(m_mode == 1));
            chk("done", 32'(done), 32'(m_mode == 2));
            chk("hit", 32'(hit), 32'(m_hit));
            chk("match_cnt", 32'(match_cnt), 32'(m_cnt));
            chk("first_pos", 32'(first_pos), 32'(m_first));
        end
    end

    task automatic step(input bit b, input bit v);
        @(negedge clk);
        start = 1'b0; din = b; in_valid = v;
    endtask

    task automatic do_start(input logic [3:0] p, input logic [7:0] l);
        @(negedge clk);
        start = 1'b1; pattern = p; win_len = l; in_valid = 1'b0; din = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        step(1'b0, 1'b0);
        while (!done && n < 40) begin
            step(1'b0, 1'b0);
            n++;
        end
        chk("done_reached", 32'(done), 32'd1);
    endtask

    bit s[10] = '{1, 1, 0, 1, 1, 0, 1, 1, 1, 0};

    task automatic check_030(input string tag);
        chk({tag, "_cnt"}, 32'(match_cnt), OVERLAP ? 32'd2 : 32'd1);
        chk({tag, "_first"}, 32'(first_pos), 32'd4);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int busy_cycles;
        repeat (2) @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_first_pos", 32'(first_pos), 32'hFF);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        // basic stream
        do_start(4'b1011, 8'd10);
        for (int i = 0; i < 10; i++) step(s[i], 1'b1);
        wait_done();
        check_030("basic");

        // stalls after idx 2; busy must last 3 cycles longer
        do_start(4'b1011, 8'd10);
        busy_cycles = 0;
        for (int i = 0; i < 10; i++) begin
            step(s[i], 1'b1);
            if (busy) busy_cycles++;
            if (i == 2) for (int j = 0; j < 3; j++) begin
                step(1'b0, 1'b0);
                if (busy) busy_cycles++;
            end
        end
        wait_done();
        check_030("stall");
        chk("stall_busy_cycles", 32'(busy_cycles), 32'd13);

        // zero-length window
        do_start(4'b0000, 8'd0);
        step(1'b0, 1'b0);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_cnt", 32'(match_cnt), 32'd0);
        chk("zero_first", 32'(first_pos), 32'hFF);
        step(1'b0, 1'b1);
        chk("zero_hit", 32'(hit), 32'd0);

        // reset mid-scan
        do_start(4'b1011, 8'd10);
        for (int i = 0; i < 5; i++) step(s[i], 1'b1);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_cnt", 32'(match_cnt), 32'd0);
        chk("midrst_first", 32'(first_pos), 32'hFF);
        rst = 1'b0;
        do_start(4'b1011, 8'd10);
        for (int i = 0; i < 10; i++) step(s[i], 1'b1);
        wait_done();
        check_030("after_rst");

        // start during scan is ignored
        do_start(4'b1011, 8'd10);
        for (int i = 0; i < 10; i++) begin
            step(s[i], 1'b1);
            if (i == 3) begin
                start = 1'b1; pattern = 4'b0000; win_len = 8'd3;
            end
        end
        wait_done();
        check_030("ignore_start");

        // all-zero stream into the 3-bit instance
        do_start(4'b0000, 8'd7);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1);
        wait_done();
        chk("w3_done", 32'(done3), 32'd1);
        chk("w3_cnt", 32'(match_cnt3), OVERLAP ? 32'd4 : 32'd1);
        chk("w3_first", 32'(first_pos3), 32'd3);
        chk("w8_cnt", 32'(match_cnt), OVERLAP ? 32'd4 : 32'd1);

        step(1'b0, 1'b0);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
